// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling; optional even parity (8E1) when
// the macro UART_RX_PARITY_EN is defined.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
`endif

    state_t           state, state_d;
    logic             rx_meta, rx_s, rx_prev;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       shift, shift_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       data_d;
    logic             valid_d, err_d, busy_d;
`ifdef UART_RX_PARITY_EN
    logic             par_ok, par_ok_d;
`endif

    // Two-flop synchronizer plus edge-history flop; idle-high after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= 8'h00;
            bit_idx   <= 3'd0;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok    <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            shift     <= shift_d;
            bit_idx   <= bit_idx_d;
            data      <= data_d;
            valid     <= valid_d;
            frame_err <= err_d;
            busy      <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_ok    <= par_ok_d;
`endif
        end
    end

    // Next-state and next-output logic; outputs land in the DONE cycle.
    always_comb begin
        state_d   = state;
        cnt_d     = CNT_W'(cnt + 1'b1);
        shift_d   = shift;
        bit_idx_d = bit_idx;
        data_d    = data;
        valid_d   = 1'b0;
        err_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d  = par_ok;
`endif
        case (state)
            IDLE: begin
                cnt_d = '0;
                // Requires a genuine 1->0 edge, so a held break cannot retrigger.
                if (rx_prev && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift[7:1]};
                    bit_idx_d = 3'(bit_idx + 3'd1);
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_M1) begin
                    cnt_d    = '0;
                    par_ok_d = ((^shift) == rx_s);
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef UART_RX_PARITY_EN
                    if (rx_s && par_ok) begin
`else
                    if (rx_s) begin
`endif
                        data_d  = shift;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames
// scored against a frame-level reference model.
module tb_uart_receiver;

    localparam int unsigned C = 16;
    localparam int unsigned H = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NBITS_TO_STOP = 10;
`else
    localparam int unsigned NBITS_TO_STOP = 9;
`endif
    localparam int unsigned LAT = 2 + H + NBITS_TO_STOP * C;

    logic       clk = 1'b0;
    logic       reset;
    logic       RX;
    logic [7:0] data;
    logic       valid, busy, frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    uart_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .RX(RX),
        .data(data), .valid(valid), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         vcount = 0, ecount = 0, both = 0;
    int         last_valid_cyc = 0;
    logic [7:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vcount++;
            last_valid_cyc = cyc;
            got_q.push_back(data);
        end
        if (frame_err) ecount++;
        if (valid && frame_err) both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        wait_cyc(C);
    endtask

    // Parity bit is transmitted only in the 8E1 build.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
    endtask

    function automatic logic [7:0] pop_got();
        if (got_q.size() > 0) return got_q.pop_front();
        return 8'hxx;
    endfunction

    int         v0, e0, t0, lat, gap;
    logic [7:0] model_data;
    logic [7:0] exp_q[$];
    int         exp_err;
    logic [7:0] rb;
    logic       rstop, rpar, good;

    initial begin
        RX = 1'b1;
        reset = 1'b1;
        wait_cyc(3);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_cyc(4);

        // Good frame 0xA5, latency and busy during the frame.
        v0 = vcount; e0 = ecount;
        t0 = cyc;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("a5_busy_mid", 32'(busy), 32'd1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        send_bit(1'b1);
        wait_cyc(2 * C);
        chk("a5_vcount", 32'(vcount - v0), 32'd1);
        chk("a5_data_pulse", 32'(pop_got()), 32'hA5);
        chk("a5_data_hold", 32'(data), 32'hA5);
        chk("a5_no_err", 32'(ecount - e0), 32'd0);
        lat = last_valid_cyc - (t0 + 1);
        chk("a5_latency_in_window", 32'((lat >= int'(LAT) - 1) && (lat <= int'(LAT) + 1)), 32'd1);
        chk("a5_busy_idle", 32'(busy), 32'd0);

        // Short low glitch is rejected at the start-bit check.
        v0 = vcount; e0 = ecount;
        RX = 1'b0;
        wait_cyc(5);
        RX = 1'b1;
        wait_cyc(12);
        chk("glitch_busy", 32'(busy), 32'd0);
        wait_cyc(C);
        chk("glitch_no_valid", 32'(vcount - v0), 32'd0);
        chk("glitch_no_err", 32'(ecount - e0), 32'd0);

        // Bad stop bit: error pulse, data retained.
        v0 = vcount; e0 = ecount;
        send_frame(8'h3C, ^8'h3C, 1'b0);
        RX = 1'b1;
        wait_cyc(2 * C);
        chk("badstop_err", 32'(ecount - e0), 32'd1);
        chk("badstop_no_valid", 32'(vcount - v0), 32'd0);
        chk("badstop_data_kept", 32'(data), 32'hA5);

        // Back-to-back frames with no idle gap.
        v0 = vcount;
        send_frame(8'h00, ^8'h00, 1'b1);
        send_frame(8'hFF, ^8'hFF, 1'b1);
        send_frame(8'h55, ^8'h55, 1'b1);
        wait_cyc(2 * C);
        chk("b2b_vcount", 32'(vcount - v0), 32'd3);
        chk("b2b_0", 32'(pop_got()), 32'h00);
        chk("b2b_1", 32'(pop_got()), 32'hFF);
        chk("b2b_2", 32'(pop_got()), 32'h55);

        // Break: exactly one error, no retrigger while held low.
        v0 = vcount; e0 = ecount;
        RX = 1'b0;
        wait_cyc(30 * C);
        chk("break_one_err", 32'(ecount - e0), 32'd1);
        chk("break_no_valid", 32'(vcount - v0), 32'd0);
        chk("break_busy", 32'(busy), 32'd0);
        RX = 1'b1;
        wait_cyc(2 * C);
        chk("break_release_err", 32'(ecount - e0), 32'd1);

        // Reset during bit 4 of 0x81, then a clean 0x7E.
        v0 = vcount; e0 = ecount;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        RX = 1'b0;
        wait_cyc(H);
        reset = 1'b1;
        RX = 1'b1;
        wait_cyc(3);
        chk("midrst_data", 32'(data), 32'h00);
        chk("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_cyc(12 * C);
        chk("midrst_no_valid", 32'(vcount - v0), 32'd0);
        chk("midrst_no_err", 32'(ecount - e0), 32'd0);
        send_frame(8'h7E, ^8'h7E, 1'b1);
        wait_cyc(2 * C);
        chk("after_rst_vcount", 32'(vcount - v0), 32'd1);
        chk("after_rst_data", 32'(pop_got()), 32'h7E);
        chk("after_rst_no_err", 32'(ecount - e0), 32'd0);

`ifdef UART_RX_PARITY_EN
        v0 = vcount; e0 = ecount;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cyc(2 * C);
        chk("par1_valid", 32'(vcount - v0), 32'd1);
        chk("par1_data", 32'(pop_got()), 32'h07);
        chk("par1_no_err", 32'(ecount - e0), 32'd0);
        v0 = vcount; e0 = ecount;
        send_frame(8'h07, 1'b0, 1'b1);
        wait_cyc(2 * C);
        chk("par0_err", 32'(ecount - e0), 32'd1);
        chk("par0_no_valid", 32'(vcount - v0), 32'd0);
`endif

        // Random frames vs. frame-level reference model.
        got_q.delete();
        model_data = 8'h7E;
        exp_err = 0;
        e0 = ecount;
        for (int k = 0; k < 24; k++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rpar  = (^rb) ^ ($urandom_range(0, 4) == 0);
`ifdef UART_RX_PARITY_EN
            good = rstop && (rpar == ^rb);
`else
            good = rstop;
`endif
            if (good) begin
                exp_q.push_back(rb);
                model_data = rb;
            end else begin
                exp_err++;
            end
            send_frame(rb, rpar, rstop);
            RX = 1'b1;
            gap = rstop ? int'($urandom_range(0, C)) : int'(C);
            wait_cyc(gap);
        end
        wait_cyc(2 * C);
        chk("rnd_vcount", 32'(got_q.size()), 32'(exp_q.size()));
        chk("rnd_errcount", 32'(ecount - e0), 32'(exp_err));
        while (exp_q.size() > 0) begin
            chk("rnd_data", 32'(pop_got()), 32'(exp_q.pop_front()));
        end
        chk("rnd_final_data", 32'(data), 32'(model_data));
        chk("never_valid_and_err", 32'(both), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit period, legal range 4 to 65535.
REQ-002 Port clk, input, 1 bit: sole clock; all logic samples on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port RX, input, 1 bit: asynchronous serial line; idle high; LSB first; 8N1, or 8E1 when the macro in REQ-030 is defined.
REQ-005 Port data, output, 8 bits: last received byte; holds its value until the next accepted frame.
REQ-006 Port valid, output, 1 bit: one-cycle pulse marking a new value on data.
REQ-007 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-008 Port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit, or a bad parity bit when REQ-030 is enabled.

Function
REQ-009 RX shall pass through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s.
REQ-010 FSM states shall be IDLE, START, DATA, PARITY, STOP and DONE; PARITY exists only when REQ-030 is enabled.
REQ-011 IDLE: a falling edge on rx_s (1 then 0) shall move to START and clear the bit-period counter.
REQ-012 START: at count CLKS_PER_BIT/2-1 (integer division), rx_s=0 shall move to DATA with the counter cleared.
REQ-013 START: at the same count, rx_s=1 is a glitch; the FSM shall return to IDLE with no valid and no frame_err.
REQ-014 DATA: one bit shall be sampled every CLKS_PER_BIT cycles, at mid-bit, and shifted in LSB first, giving exactly 8 samples.
REQ-015 DATA: after the 8th sample, the FSM shall go to PARITY or STOP.
REQ-016 PARITY: one sample shall be taken at mid-bit; parity_ok is true when XOR of the 8 data bits equals the sampled parity bit (even parity).
REQ-017 STOP: one sample shall be taken at mid-bit; rx_s=1 and parity_ok (or no parity) means the frame is good; anything else means the frame is bad.
REQ-018 STOP to DONE: the transition shall occur on the stop-bit sample cycle.
REQ-019 DONE, good frame: data shall be updated and valid pulsed high for exactly that cycle.
REQ-020 DONE, bad frame: frame_err shall pulse for that cycle; data shall be unchanged and valid shall stay low.
REQ-021 DONE shall always return to IDLE on the next cycle.
REQ-022 Latency: valid shall assert on cycle 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (10*CLKS_PER_BIT with parity) after the RX falling edge, ±1 cycle of synchronizer phase.
REQ-023 A start edge arriving during the second half of the stop bit shall be detected in IDLE without loss; back-to-back frames shall all be received.
REQ-024 RX held low (break) shall produce one frame_err, and no new frame shall start until rx_s returns high.
REQ-025 valid and frame_err shall never be high in the same cycle.
REQ-026 The counter shall be ceil(log2(CLKS_PER_BIT)) bits wide, saturate-free, and clear on every state change.

Reset
REQ-027 Asserting reset shall immediately force the state to IDLE and set data=8'h00, valid=0, frame_err=0 and busy=0.
REQ-028 Asserting reset shall force the synchronizer flops to 1 and clear the counter and shift register.
REQ-029 Reset mid-frame shall abandon the frame with no valid or frame_err; reception resumes on the first falling edge after reset deasserts.

Configuration
REQ-030 Macro UART_RX_PARITY_EN: when defined, the PARITY state and even-parity check are compiled in and a frame is 11 bits.
REQ-031 When UART_RX_PARITY_EN is undefined, there is no PARITY state or logic, the frame is 10 bits, and a received stop bit directly follows bit 7.

Verification
REQ-032 CLKS_PER_BIT=16, 8N1 frame with byte 8'hA5, stop bit 1 -> one valid pulse, data=8'hA5, frame_err never high, busy high for the frame.
REQ-033 RX low for 5 cycles, then high -> no valid, no frame_err; busy returns to 0 by cycle 8 + sync.
REQ-034 Byte 8'h3C sent with stop bit 0 -> one frame_err pulse, no valid, data keeps its previous value.
REQ-035 Bytes 8'h00, 8'hFF, 8'h55 sent back to back with no idle gap -> three valid pulses, in order, with matching data.
REQ-036 Reset asserted at data bit 4 of 8'h81, then frame 8'h7E sent -> no output for 8'h81; valid with data=8'h7E.
REQ-037 With UART_RX_PARITY_EN defined: 8'h07 with parity bit 1 -> valid, data=8'h07; same byte with parity bit 0 -> frame_err, no valid.
